spi_share_ctrl: RTL and testbench
=================================

SPI_SHARE_CTRL -- requirements
Module: spi_share_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 4: SCK half-period in axi_aclk cycles; legal range 1..255.
REQ-002 Parameter WORD_W, default 16: bits per SPI transaction; legal range 2..32.
REQ-003 axi_aclk  in  1  sole clock; all logic on rising edge.
REQ-004 axi_reset  in  1  synchronous, active-high reset.
REQ-005 req0_valid  in  1  requester 0 has a word to send.
REQ-006 req0_data  in  WORD_W  requester 0 TX word, MSB first.
REQ-007 req0_ready  out  1  one-cycle grant/accept pulse to requester 0.
REQ-008 rsp0_valid  out  1  one-cycle pulse: rsp0_data holds requester 0 RX word.
REQ-009 rsp0_data  out  WORD_W  RX word for requester 0.
REQ-010 req1_valid, req1_data, req1_ready, rsp1_valid, rsp1_data: same as REQ-005..009, for requester 1.
REQ-011 spi_sck_o  out  1  SPI clock, mode 0 (idle low).
REQ-012 spi_ss_o  out  1  chip select, active low.
REQ-013 spi_mosi_o  out  1  serial data out.
REQ-014 spi_miso_i  in  1  serial data in; already synchronous to axi_aclk.
REQ-015 spi_t  out  1  IOBUF tristate for sck/ss/mosi; 1 = high-Z.
REQ-016 busy  out  1  high from grant cycle through end of gap phase.

Function
REQ-017 The block SHALL implement states IDLE, SHIFT_LO, SHIFT_HI, HOLD, DONE and GAP.
REQ-018 IDLE: if any reqN_valid is high, the block SHALL grant exactly one requester, pulse its reqN_ready for 1 cycle, capture reqN_data, and go to SHIFT_LO.
REQ-019 Arbitration SHALL be round-robin:
- Single requester: that requester wins.
- Both requesting: the requester not granted last wins.
- After reset: requester 0 wins the first tie.
REQ-020 Requester rules:
- reqN_valid shall stay high and reqN_data stable until reqN_ready.
- The block SHALL NOT pulse ready unless valid is high.
REQ-021 spi_ss_o SHALL go low the cycle after the grant and stay low for exactly 2*WORD_W*CLK_DIV + CLK_DIV cycles.
REQ-022 Each bit SHALL take one SHIFT_LO phase then one SHIFT_HI phase, each CLK_DIV cycles long:
- SHIFT_LO: sck=0, mosi = current bit.
- SHIFT_HI: sck=1.
REQ-023 Bits SHALL be sent MSB first; mosi SHALL change only in the first cycle of SHIFT_LO.
REQ-024 spi_miso_i SHALL be sampled into an RX shift register in the first cycle of each SHIFT_HI phase.
REQ-025 After the last SHIFT_HI the block SHALL enter HOLD: sck=0 and ss low for CLK_DIV cycles.
REQ-026 DONE (1 cycle):
- spi_ss_o=1.
- The granted requester's rspN_valid SHALL pulse and its rspN_data SHALL load the RX word.
- The other requester's rsp outputs SHALL be unchanged.
REQ-027 rspN_data SHALL hold its value until that requester's next DONE.
REQ-028 GAP: ss high and sck low for CLK_DIV cycles, then return to IDLE; the earliest next grant is the first IDLE cycle.
REQ-029 The transaction period, grant to next possible grant, SHALL be 2*WORD_W*CLK_DIV + 2*CLK_DIV + 2 cycles (138 at defaults).
REQ-030 reqN_valid changes during a transaction SHALL have no effect until IDLE.
REQ-031 A bit counter SHALL count 0..WORD_W-1 without wrap-around and a divider counter 0..CLK_DIV-1; CLK_DIV=1 SHALL yield sck at axi_aclk/2.
REQ-032 busy SHALL be 1 in the grant cycle and in every non-IDLE state.

Reset
REQ-033 While axi_reset=1, outputs SHALL be:
- spi_t=1, spi_ss_o=1, spi_sck_o=0, spi_mosi_o=0.
- req0_ready=req1_ready=0, rsp0_valid=rsp1_valid=0.
- rsp0_data=rsp1_data=0, busy=0.
- State = IDLE; round-robin pointer favours requester 0.
REQ-034 spi_t SHALL go to 0 on the first cycle after axi_reset deasserts.
REQ-035 Reset asserted mid-transaction SHALL abort the transaction:
- ss=1 and sck=0 on the next cycle.
- No rsp pulse.
- No partial RX data visible.

Verification
REQ-036 Defaults, req0 sends 0xA5C3 with miso looped to mosi:
- req0_ready pulses once.
- ss low 132 cycles; 16 sck rising edges, each 8 cycles apart.
- rsp0_valid pulses with rsp0_data=0xA5C3; busy falls 138 cycles after the grant.
REQ-037 req0 and req1 both asserted continuously from reset: grants alternate 0,1,0,1; each grant is 138 cycles after the previous.
REQ-038 Only req1 requests, three times back-to-back: all three granted to req1; rsp0_valid never pulses.
REQ-039 miso tied 1, req1 sends 0x0000: rsp1_data=0xFFFF; mosi stays 0 for the whole transaction.
REQ-040 Reset asserted at bit 7 of a transaction:
- Next cycle ss=1, sck=0, busy=0; no rsp pulse.
- After release, a tie is granted to req0.
REQ-041 CLK_DIV=1, WORD_W=8, req0 sends 0x81: sck period 2 cycles, ss low 17 cycles, mosi pattern 1,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/spi_share_ctrl.sv
// spi_share_ctrl: shares one SPI master (mode 0, MSB first) between two
// requesters using round-robin arbitration. One word per transaction; each
// transaction is SHIFT bits, a HOLD tail, a 1-cycle DONE and a GAP with ss high.
module spi_share_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int WORD_W  = 16
) (
  input  logic              axi_aclk,
  input  logic              axi_reset,
  input  logic              req0_valid,
  input  logic [WORD_W-1:0] req0_data,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [WORD_W-1:0] rsp0_data,
  input  logic              req1_valid,
  input  logic [WORD_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [WORD_W-1:0] rsp1_data,
  output logic              spi_sck_o,
  output logic              spi_ss_o,
  output logic              spi_mosi_o,
  input  logic              spi_miso_i,
  output logic              spi_t,
  output logic              busy
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(WORD_W);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SHIFT_LO = 3'd1;
  localparam logic [2:0] S_SHIFT_HI = 3'd2;
  localparam logic [2:0] S_HOLD     = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;
  localparam logic [2:0] S_GAP      = 3'd5;

  logic [2:0]        r_state;
  logic [DW-1:0]     r_div;
  logic [BW-1:0]     r_bit;
  logic [WORD_W-1:0] r_sh;    // TX word; MSB drives mosi
  logic [WORD_W-1:0] r_rx;    // RX shift register, only exposed at DONE
  logic              r_who;   // requester owning the current transaction
  logic              r_prio;  // requester that wins the next tie
  logic [WORD_W-1:0] r_rsp0;
  logic [WORD_W-1:0] r_rsp1;

  logic w_any, w_win, w_grant, w_div_end, w_ss_low;

  // Arbitration: a lone requester wins, a tie goes to r_prio.
  always_comb begin
    w_any     = req0_valid | req1_valid;
    w_win     = (req0_valid & req1_valid) ? r_prio : req1_valid;
    w_grant   = ~axi_reset & (r_state == S_IDLE) & w_any;
    w_div_end = (r_div == DIV_LAST);
    w_ss_low  = (r_state == S_SHIFT_LO) | (r_state == S_SHIFT_HI) | (r_state == S_HOLD);
  end

  // Transaction sequencer: phase timing, TX shift, RX sampling, response load.
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_rx    <= '0;
      r_who   <= 1'b0;
      r_prio  <= 1'b0;
      r_rsp0  <= '0;
      r_rsp1  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_grant) begin
          r_sh    <= w_win ? req1_data : req0_data;
          r_who   <= w_win;
          r_prio  <= ~w_win;
          r_div   <= '0;
          r_bit   <= '0;
          r_state <= S_SHIFT_LO;
        end
        S_SHIFT_LO: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_state <= S_SHIFT_HI;
          end else r_div <= r_div + DW'(1);
        end
        S_SHIFT_HI: begin
          if (r_div == '0) r_rx <= {r_rx[WORD_W-2:0], spi_miso_i};
          if (w_div_end) begin
            r_div <= '0;
            if (r_bit == BIT_LAST) r_state <= S_HOLD;
            else begin
              // next bit appears on mosi in the first cycle of SHIFT_LO
              r_bit   <= r_bit + BW'(1);
              r_sh    <= r_sh << 1;
              r_state <= S_SHIFT_LO;
            end
          end else r_div <= r_div + DW'(1);
        end
        S_HOLD: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_state <= S_DONE;
            if (r_who) r_rsp1 <= r_rx;
            else       r_rsp0 <= r_rx;
          end else r_div <= r_div + DW'(1);
        end
        S_DONE: begin
          r_div   <= '0;
          r_state <= S_GAP;
        end
        S_GAP: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_state <= S_IDLE;
          end else r_div <= r_div + DW'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Pin and handshake decode; reset forces the safe values immediately.
  always_comb begin
    spi_t      = axi_reset;
    spi_ss_o   = axi_reset | ~w_ss_low;
    spi_sck_o  = ~axi_reset & (r_state == S_SHIFT_HI);
    spi_mosi_o = ~axi_reset & r_sh[WORD_W-1];
    req0_ready = w_grant & ~w_win;
    req1_ready = w_grant & w_win;
    rsp0_valid = ~axi_reset & (r_state == S_DONE) & ~r_who;
    rsp1_valid = ~axi_reset & (r_state == S_DONE) & r_who;
    rsp0_data  = r_rsp0;
    rsp1_data  = r_rsp1;
    busy       = ~axi_reset & ((r_state != S_IDLE) | w_any);
  end

endmodule

// File: tb/tb_spi_share_ctrl.sv
// Bench for spi_share_ctrl: cycle-level transaction model for a default
// instance plus literal checks, and a small CLK_DIV=1/WORD_W=8 instance.
module tb_spi_share_ctrl;
  localparam int W0  = 16;
  localparam int D0  = 4;
  localparam int SH0 = 2 * W0 * D0;          // shift cycles
  localparam int HE0 = SH0 + D0;             // last HOLD offset from grant
  localparam int P0  = SH0 + 2 * D0 + 2;     // grant-to-grant period

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  v;
  logic [15:0] d [2];
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [15:0] rsp0_data, rsp1_data;
  logic spi_sck_o, spi_ss_o, spi_mosi_o, spi_t, busy, spi_miso, miso_rand;
  int   miso_mode;  // 0 loopback, 1 random, 2 tied high
  assign spi_miso = (miso_mode == 0) ? spi_mosi_o : (miso_mode == 1) ? miso_rand : 1'b1;

  spi_share_ctrl #(.CLK_DIV(D0), .WORD_W(W0)) dut (
    .axi_aclk(clk), .axi_reset(rst),
    .req0_valid(v[0]), .req0_data(d[0]), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .req1_valid(v[1]), .req1_data(d[1]), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .spi_sck_o(spi_sck_o), .spi_ss_o(spi_ss_o), .spi_mosi_o(spi_mosi_o),
    .spi_miso_i(spi_miso), .spi_t(spi_t), .busy(busy));

  logic       bv, b_ready, b_rv, b_r1ready, b_r1v, b_sck, b_ss, b_mosi, b_t, b_busy;
  logic [7:0] bd, b_rd, b_r1d;
  logic       b_zero = 1'b0;
  logic [7:0] b_zd = 8'h00;

  spi_share_ctrl #(.CLK_DIV(1), .WORD_W(8)) dut_b (
    .axi_aclk(clk), .axi_reset(rst),
    .req0_valid(bv), .req0_data(bd), .req0_ready(b_ready),
    .rsp0_valid(b_rv), .rsp0_data(b_rd),
    .req1_valid(b_zero), .req1_data(b_zd), .req1_ready(b_r1ready),
    .rsp1_valid(b_r1v), .rsp1_data(b_r1d),
    .spi_sck_o(b_sck), .spi_ss_o(b_ss), .spi_mosi_o(b_mosi),
    .spi_miso_i(b_mosi), .spi_t(b_t), .busy(b_busy));

  int checks = 0, errors = 0, cyc = 0;

  // model state
  bit          m_act, m_who, m_prio, m_mosi;
  int          m_t;
  logic [15:0] m_data, m_rx;
  logic [15:0] m_rsp [2] = '{16'h0, 16'h0};

  // observation logs
  int ss_low = 0, mosi_hi = 0, rsp_cnt [2] = '{0, 0};
  bit sck_p, busy_p;
  int q_rise[$], q_gc[$], q_gw[$], q_bf[$];
  int b_ss_low = 0, b_rsp_cnt = 0;
  bit b_sck_p;
  int b_rise[$];
  logic [7:0] b_bits;

  // stimulus control
  int gen_mode [2] = '{0, 0};  // 0 none, 1 continuous, 2 random
  int shot_req [2] = '{0, 0};
  int shot_done [2] = '{0, 0};
  logic [15:0] shot_data [2];
  logic [1:0] acc;
  bit bacc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  // One clock: check at negedge, advance model, then drive after posedge.
  task automatic tick();
    logic e_ss, e_sck, e_mosi, e_busy;
    logic [1:0] e_rdy, e_rspv;
    bit win;
    int k;
    @(negedge clk);
    cyc++;
    win = (v[0] && v[1]) ? m_prio : v[1];
    e_rdy = 2'b00; e_rspv = 2'b00; e_busy = 1'b0;
    e_ss = 1'b1; e_sck = 1'b0; e_mosi = m_mosi;
    k = m_t - 1;
    if (rst) e_mosi = 1'b0;
    else if (m_act) begin
      e_busy = 1'b1;
      if (m_t <= HE0) begin
        e_ss = 1'b0;
        if (k < SH0) begin
          e_sck  = ((k % (2 * D0)) >= D0);
          e_mosi = m_data[W0 - 1 - k / (2 * D0)];
        end else e_mosi = m_data[0];
      end else begin
        e_mosi = m_data[0];
        if (m_t == HE0 + 1) e_rspv[m_who] = 1'b1;
      end
    end else if (v[0] | v[1]) begin
      e_busy = 1'b1;
      e_rdy[win] = 1'b1;
    end
    chk("pins", 32'({spi_ss_o, spi_sck_o, spi_mosi_o, busy, spi_t, req1_ready, req0_ready, rsp1_valid, rsp0_valid}),
        32'({e_ss, e_sck, e_mosi, e_busy, rst, e_rdy, e_rspv}));
    chk("rsp0_data", 32'(rsp0_data), 32'(m_rsp[0]));
    chk("rsp1_data", 32'(rsp1_data), 32'(m_rsp[1]));

    if (!spi_ss_o) ss_low++;
    if (!spi_ss_o && spi_mosi_o) mosi_hi++;
    if (spi_sck_o && !sck_p) q_rise.push_back(cyc);
    sck_p = spi_sck_o;
    if (busy_p && !busy) q_bf.push_back(cyc);
    busy_p = busy;
    if (req0_ready | req1_ready) begin q_gc.push_back(cyc); q_gw.push_back(int'(req1_ready)); end
    if (rsp0_valid) rsp_cnt[0]++;
    if (rsp1_valid) rsp_cnt[1]++;
    if (!b_ss) b_ss_low++;
    if (b_sck && !b_sck_p) begin b_rise.push_back(cyc); b_bits = {b_bits[6:0], b_mosi}; end
    b_sck_p = b_sck;
    if (b_rv) b_rsp_cnt++;
    acc = {req1_ready, req0_ready};
    bacc = b_ready;

    if (rst) begin
      m_act = 1'b0; m_prio = 1'b0; m_mosi = 1'b0; m_rsp[0] = '0; m_rsp[1] = '0;
    end else if (m_act) begin
      if (k < SH0 && (k % (2 * D0)) == D0) m_rx = {m_rx[W0-2:0], spi_miso};
      if (m_t == HE0) m_rsp[m_who] = m_rx;
      m_t++;
      if (m_t == P0) begin m_act = 1'b0; m_mosi = m_data[0]; end
    end else if (v[0] | v[1]) begin
      m_act = 1'b1; m_t = 1; m_who = win; m_data = d[win]; m_prio = !win;
    end

    @(posedge clk);
    #1;
    for (int n = 0; n < 2; n++) begin
      if (acc[n]) v[n] = 1'b0;
      if (!v[n]) begin
        if (shot_done[n] != shot_req[n]) begin
          v[n] = 1'b1; d[n] = shot_data[n]; shot_done[n]++;
        end else if (gen_mode[n] == 1 || (gen_mode[n] == 2 && $urandom_range(3) == 0)) begin
          v[n] = 1'b1; d[n] = 16'($urandom);
        end
      end
    end
    miso_rand = 1'($urandom);
    if (bacc) bv = 1'b0;
  endtask

  task automatic wait_grant(input int n0);
    int lim = 400;
    while (q_gc.size() == n0 && lim > 0) begin tick(); lim--; end
    chk("grant_seen", 32'(q_gc.size() > n0), 32'd1);
  endtask

  int g0, r0, s0, m0, rc0, rc1, bad, last;

  initial begin
    v = 2'b00; d[0] = '0; d[1] = '0; bv = 1'b0; bd = '0; miso_mode = 0; miso_rand = 1'b0;
    shot_data[0] = '0; shot_data[1] = '0; b_bits = '0;
    repeat (4) tick();
    chk("rst_rsp0", 32'(rsp0_data), 32'h0);
    chk("rst_ss", 32'(spi_ss_o), 32'd1);
    rst = 1'b0;

    // single word, loopback
    g0 = q_gc.size(); r0 = q_rise.size(); s0 = ss_low; rc0 = rsp_cnt[0];
    shot_data[0] = 16'hA5C3; shot_req[0]++;
    repeat (160) tick();
    chk("t1_grants", 32'(q_gc.size() - g0), 32'd1);
    chk("t1_who", (q_gc.size() > g0) ? 32'(q_gw[g0]) : 32'hFFFF_FFFF, 32'd0);
    chk("t1_ss_low", 32'(ss_low - s0), 32'd132);
    chk("t1_rises", 32'(q_rise.size() - r0), 32'd16);
    bad = 0;
    for (int i = r0 + 1; i < q_rise.size(); i++) if (q_rise[i] - q_rise[i-1] != 8) bad++;
    chk("t1_rise_spacing", 32'(bad), 32'd0);
    chk("t1_rsp_cnt", 32'(rsp_cnt[0] - rc0), 32'd1);
    chk("t1_rsp_data", 32'(rsp0_data), 32'hA5C3);
    last = (q_bf.size() > 0) ? q_bf[q_bf.size()-1] : 0;
    chk("t1_busy_len", (q_gc.size() > g0) ? 32'(last - q_gc[g0]) : 32'hFFFF_FFFF, 32'd138);

    // miso tied high, zero word from requester 1
    miso_mode = 2; m0 = mosi_hi;
    shot_data[1] = 16'h0000; shot_req[1]++;
    repeat (160) tick();
    chk("t2_rsp1_data", 32'(rsp1_data), 32'hFFFF);
    chk("t2_mosi_high", 32'(mosi_hi - m0), 32'd0);
    chk("t2_rsp0_kept", 32'(rsp0_data), 32'hA5C3);

    // both requesting continuously from reset
    miso_mode = 1; rst = 1'b1; gen_mode[0] = 1; gen_mode[1] = 1;
    repeat (3) tick();
    rst = 1'b0; g0 = q_gc.size();
    repeat (4 * P0 + 20) tick();
    chk("t3_grants", 32'(q_gc.size() - g0 >= 4), 32'd1);
    for (int i = 0; i < 4; i++)
      if (q_gc.size() > g0 + i) chk("t3_order", 32'(q_gw[g0+i]), 32'(i % 2));
    for (int i = 1; i < 4; i++)
      if (q_gc.size() > g0 + i) chk("t3_period", 32'(q_gc[g0+i] - q_gc[g0+i-1]), 32'd138);
    gen_mode[0] = 0; gen_mode[1] = 0;
    repeat (450) tick();

    // requester 1 alone, three back-to-back
    g0 = q_gc.size(); rc0 = rsp_cnt[0]; rc1 = rsp_cnt[1];
    shot_data[1] = 16'h3C5A; shot_req[1] += 3;
    repeat (3 * P0 + 20) tick();
    chk("t4_grants", 32'(q_gc.size() - g0), 32'd3);
    bad = 0;
    for (int i = g0; i < q_gc.size(); i++) if (q_gw[i] != 1) bad++;
    chk("t4_all_req1", 32'(bad), 32'd0);
    chk("t4_no_rsp0", 32'(rsp_cnt[0] - rc0), 32'd0);
    chk("t4_rsp1_cnt", 32'(rsp_cnt[1] - rc1), 32'd3);

    // reset during bit 7
    g0 = q_gc.size();
    shot_data[0] = 16'h5AA5; shot_req[0]++;
    wait_grant(g0);
    repeat (57) tick();
    rc0 = rsp_cnt[0]; rc1 = rsp_cnt[1];
    rst = 1'b1;
    tick();
    chk("t5_ss", 32'(spi_ss_o), 32'd1);
    chk("t5_sck", 32'(spi_sck_o), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    shot_data[0] = 16'h1111; shot_data[1] = 16'h2222; shot_req[0]++; shot_req[1]++;
    repeat (2) tick();
    rst = 1'b0; g0 = q_gc.size();
    wait_grant(g0);
    chk("t5_tie_req0", (q_gc.size() > g0) ? 32'(q_gw[g0]) : 32'hFFFF_FFFF, 32'd0);
    chk("t5_no_rsp", 32'(rsp_cnt[0] - rc0 + rsp_cnt[1] - rc1), 32'd0);
    repeat (2 * P0 + 10) tick();

    // randomized traffic with occasional reset pulses
    gen_mode[0] = 2; gen_mode[1] = 2; miso_mode = 1;
    repeat (6000) begin
      rst = ($urandom_range(1999) == 0);
      tick();
    end
    rst = 1'b0; gen_mode[0] = 0; gen_mode[1] = 0; miso_mode = 0;
    repeat (450) tick();

    // fastest divider, 8-bit word
    r0 = b_rise.size(); s0 = b_ss_low; rc0 = b_rsp_cnt; b_bits = '0;
    bd = 8'h81; bv = 1'b1;
    repeat (40) tick();
    chk("t6_rises", 32'(b_rise.size() - r0), 32'd8);
    bad = 0;
    for (int i = r0 + 1; i < b_rise.size(); i++) if (b_rise[i] - b_rise[i-1] != 2) bad++;
    chk("t6_sck_period", 32'(bad), 32'd0);
    chk("t6_ss_low", 32'(b_ss_low - s0), 32'd17);
    chk("t6_mosi_bits", 32'(b_bits), 32'h81);
    chk("t6_rsp_cnt", 32'(b_rsp_cnt - rc0), 32'd1);
    chk("t6_rsp_data", 32'(b_rd), 32'h81);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
